// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit in the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle. Divide-by-zero
// and signed-overflow cases bypass the iteration and finish in one cycle.
module ex_muldiv #(
  parameter int data_size = 32,
  parameter int cnt_size  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MD_Start,
  input  logic                 MD_Flush,
  input  logic [2:0]           MD_Funct3,
  input  logic [data_size-1:0] MD_A,
  input  logic [data_size-1:0] MD_B,
  output logic                 MD_Busy,
  output logic                 MD_Done,
  output logic [data_size-1:0] MD_Result
);

  localparam int W = data_size;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              r_state;
  logic [cnt_size-1:0] r_cnt;
  logic [2:0]          r_f3;
  logic                r_neg_p, r_neg_q, r_neg_r;
  logic [2*W-1:0]      r_acc, r_mc;
  logic [W-1:0]        r_mp;
  logic [W-1:0]        r_rem, r_quo, r_dvs;
  logic                r_done;
  logic [W-1:0]        r_result;

  logic           w_is_div, w_is_sdiv, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [W-1:0]   w_a_mag, w_b_mag;
  logic           w_div0, w_ovf;
  logic [W-1:0]   w_sc_res;
  logic [2*W-1:0] w_acc_nxt, w_prod;
  logic [W:0]     w_part, w_diff;
  logic           w_ge;
  logic [W-1:0]   w_rem_nxt, w_quo_nxt, w_q, w_r, w_fin;
  logic [W-1:0]   w_min_int;

  assign w_min_int = {1'b1, {(W-1){1'b0}}};

  // Operand decode: which operands are signed for this funct3, and their magnitudes
  assign w_is_div  = MD_Funct3[2];
  assign w_is_sdiv = MD_Funct3[2] & ~MD_Funct3[0];
  assign w_a_sgn   = (MD_Funct3 == 3'b000) | (MD_Funct3 == 3'b001) |
                     (MD_Funct3 == 3'b010) | w_is_sdiv;
  assign w_b_sgn   = (MD_Funct3 == 3'b000) | (MD_Funct3 == 3'b001) | w_is_sdiv;
  assign w_a_neg   = w_a_sgn & MD_A[W-1];
  assign w_b_neg   = w_b_sgn & MD_B[W-1];
  assign w_a_mag   = w_a_neg ? -MD_A : MD_A;
  assign w_b_mag   = w_b_neg ? -MD_B : MD_B;

  // Shortcut cases resolved without iterating
  assign w_div0   = w_is_div & (MD_B == '0);
  assign w_ovf    = w_is_sdiv & (MD_A == w_min_int) & (MD_B == '1);

  // Shortcut result: REM/REMU pick the remainder, DIV/DIVU the quotient
  always_comb begin
    w_sc_res = '0;
    if (w_div0)
      w_sc_res = MD_Funct3[1] ? MD_A : '1;
    else if (w_ovf)
      w_sc_res = MD_Funct3[1] ? '0 : w_min_int;
  end

  // One iteration step of multiply (shift-add) and divide (restoring)
  assign w_acc_nxt = r_mp[0] ? (r_acc + r_mc) : r_acc;
  assign w_part    = {r_rem, r_quo[W-1]};
  assign w_diff    = w_part - {1'b0, r_dvs};
  assign w_ge      = (w_part >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? w_diff[W-1:0] : w_part[W-1:0];
  assign w_quo_nxt = {r_quo[W-2:0], w_ge};

  // Final sign correction and result selection after the last iteration
  assign w_prod = r_neg_p ? -w_acc_nxt : w_acc_nxt;
  assign w_q    = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r    = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  // Pick the architectural result for the latched funct3
  always_comb begin
    w_fin = '0;
    case (r_f3)
      3'b000:                 w_fin = w_prod[W-1:0];
      3'b001, 3'b010, 3'b011: w_fin = w_prod[2*W-1:W];
      3'b100, 3'b101:         w_fin = w_q;
      default:                w_fin = w_r;
    endcase
  end

  assign MD_Busy   = (r_state == S_CALC) |
                     ((r_state == S_IDLE) & MD_Start & ~MD_Flush);
  assign MD_Done   = r_done;
  assign MD_Result = r_result;

  // Control FSM and iterative datapath; result register only written on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg_p  <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_mc     <= '0;
      r_mp     <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (MD_Start && !MD_Flush) begin
            r_f3    <= MD_Funct3;
            r_neg_p <= ~w_is_div & (w_a_neg ^ w_b_neg);
            r_neg_q <= w_is_div & (w_a_neg ^ w_b_neg);
            r_neg_r <= w_is_div & w_a_neg;
            r_acc   <= '0;
            r_mc    <= {{W{1'b0}}, w_a_mag};
            r_mp    <= w_b_mag;
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_cnt   <= cnt_size'(W - 1);
            if (w_div0 || w_ovf) begin
              r_result <= w_sc_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (MD_Flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            r_mc  <= {r_mc[2*W-2:0], 1'b0};
            r_mp  <= {1'b0, r_mp[W-1:1]};
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (r_cnt == '0) begin
              r_result <= w_fin;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vectors for the iterative multiply/divide unit.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        MD_Start;
  logic        MD_Flush;
  logic [2:0]  MD_Funct3;
  logic [31:0] MD_A;
  logic [31:0] MD_B;
  logic        MD_Busy;
  logic        MD_Done;
  logic [31:0] MD_Result;

  int total = 0;
  int bad   = 0;

  ex_muldiv #(.data_size(32), .cnt_size(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .MD_Start (MD_Start),
    .MD_Flush (MD_Flush),
    .MD_Funct3(MD_Funct3),
    .MD_A     (MD_A),
    .MD_B     (MD_B),
    .MD_Busy  (MD_Busy),
    .MD_Done  (MD_Done),
    .MD_Result(MD_Result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op in the IDLE cycle and follow it to its DONE pulse
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int  n;
    bit  seen;
    bit  busy_ok;
    @(negedge clk);
    MD_Funct3 = f3; MD_A = a; MD_B = b; MD_Start = 1'b1;
    #1;
    chk({tag, "_busy_start"}, 64'(MD_Busy), 64'(1));
    @(posedge clk); #1;
    MD_Start = 1'b0;
    #1;
    n = 1; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && n <= 40) begin
      if (MD_Done) seen = 1'b1;
      else begin
        if (!MD_Busy) busy_ok = 1'b0;
        @(posedge clk); #2;
        n++;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'(1));
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_busy_calc"}, 64'(busy_ok), 64'(1));
    chk({tag, "_busy_done"}, 64'(MD_Busy), 64'(0));
    chk({tag, "_result"}, 64'(MD_Result), 64'(exp_res));
    @(posedge clk); #2;
    chk({tag, "_done_pulse"}, 64'(MD_Done), 64'(0));
  endtask

  initial begin
    int dones;
    rst = 1'b1; MD_Start = 1'b0; MD_Flush = 1'b0;
    MD_Funct3 = 3'b000; MD_A = '0; MD_B = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_result", 64'(MD_Result), 64'(0));
    chk("rst_done", 64'(MD_Done), 64'(0));
    chk("rst_busy", 64'(MD_Busy), 64'(0));

    // Multiply family
    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    // Divide family
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33);
    // Shortcut cases
    run_op("divu0",  3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 1);
    run_op("rem0",   3'b110, 32'h1234,     32'd0,        32'h1234,     1);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("mul2",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);

    // Flush in the middle of a multiply
    @(negedge clk);
    MD_Funct3 = 3'b000; MD_A = 32'd5; MD_B = 32'd6; MD_Start = 1'b1;
    @(posedge clk); #1 MD_Start = 1'b0;
    repeat (10) @(posedge clk);
    #1 MD_Flush = 1'b1;
    @(posedge clk); #1 MD_Flush = 1'b0;
    #1;
    chk("flush_busy", 64'(MD_Busy), 64'(0));
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (MD_Done) dones++;
      @(posedge clk); #2;
    end
    chk("flush_no_done", 64'(dones), 64'(0));
    chk("flush_result", 64'(MD_Result), 64'(32'hFFFFFFEB));

    // Start and flush in the same cycle
    @(negedge clk);
    MD_Funct3 = 3'b101; MD_A = 32'd100; MD_B = 32'd7; MD_Start = 1'b1; MD_Flush = 1'b1;
    #1;
    chk("sf_busy_comb", 64'(MD_Busy), 64'(0));
    @(posedge clk); #1 MD_Start = 1'b0; MD_Flush = 1'b0;
    #1;
    chk("sf_busy_after", 64'(MD_Busy), 64'(0));
    chk("sf_done", 64'(MD_Done), 64'(0));

    // Reset in the middle of a divide
    @(negedge clk);
    MD_Funct3 = 3'b100; MD_A = 32'd100; MD_B = 32'd7; MD_Start = 1'b1;
    @(posedge clk); #1 MD_Start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("midrst_result", 64'(MD_Result), 64'(0));
    chk("midrst_done", 64'(MD_Done), 64'(0));
    chk("midrst_busy", 64'(MD_Busy), 64'(0));
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (MD_Done) dones++;
      @(posedge clk); #2;
    end
    chk("midrst_no_done", 64'(dones), 64'(0));

    // Start pulses during CALC must not queue or restart
    @(negedge clk);
    MD_Funct3 = 3'b101; MD_A = 32'd100; MD_B = 32'd7; MD_Start = 1'b1;
    @(posedge clk); #1 MD_Start = 1'b0;
    repeat (4) @(posedge clk);
    #1 MD_Funct3 = 3'b000; MD_A = 32'd3; MD_B = 32'd3; MD_Start = 1'b1;
    repeat (6) @(posedge clk);
    #1 MD_Start = 1'b0;
    #1;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (MD_Done) begin
        dones++;
        chk("ign_result", 64'(MD_Result), 64'(14));
      end
      @(posedge clk); #2;
    end
    chk("ign_one_done", 64'(dones), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
